parity_frame_checker: RTL and testbench

Serial frame receiver and sequencer for parity checking. It accepts a start strobe, then DATA_W data bits and one parity bit, all serial and qualified by a valid strobe. It then checks even or odd parity and reports the data word, an error flag and a saturating error count. It is the controller that drives parity checking over a serial link, replacing per-word combinational checking of a_in/b_in/p_in with a sequenced multi-bit frame.

---
 rtl/parity_frame_checker.sv | 165 ++++++++++++++++
 tb/tb_parity_frame_checker.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/parity_frame_checker.sv
// parity_frame_checker
//
// Serial frame receiver for parity checking. A frame is a start strobe
// followed by DATA_W data bits (LSB first) and one parity bit, each qualified
// by bit_valid_in. When the parity bit arrives, the block publishes the data
// word and a parity error flag, and pulses done_out for one cycle. It also
// keeps a saturating count of errored frames.
//
// Parameters:
//   DATA_W      data bits per frame (2..32)
//   ODD_PARITY  0 = even parity expected, 1 = odd parity expected
//   CNT_W       width of the error counter
//
// Ports:
//   clk_in        clock, rising edge
//   rst_n_in      asynchronous active-low reset
//   start_in      begin a frame (honoured only in IDLE)
//   abort_in      drop the current frame, return to IDLE
//   bit_valid_in  bit_in is valid this cycle
//   bit_in        serial data/parity bit
//   clear_cnt_in  synchronous clear of err_count_out
//   busy_out      high while a frame is in DATA, PARITY or DONE
//   data_out      last completed data word
//   done_out      one-cycle pulse when a frame completes
//   error_out     parity error of the last completed frame
//   err_count_out saturating count of errored frames

module parity_frame_checker #(
    parameter int DATA_W     = 8,
    parameter bit ODD_PARITY = 1'b0,
    parameter int CNT_W      = 8
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              start_in,
    input  logic              abort_in,
    input  logic              bit_valid_in,
    input  logic              bit_in,
    input  logic              clear_cnt_in,
    output logic              busy_out,
    output logic [DATA_W-1:0] data_out,
    output logic              done_out,
    output logic              error_out,
    output logic [CNT_W-1:0]  err_count_out
);

    localparam int IDX_W = $clog2(DATA_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [IDX_W-1:0]  bit_idx;
    logic [DATA_W-1:0] shift_reg;
    logic              run_par;
    logic              frame_accept;
    logic              frame_err;

    // The parity bit is only taken when no abort competes with it; this one
    // signal gates the result registers and the counter increment together.
    assign frame_accept = (state == PARITY) && bit_valid_in && !abort_in;
    assign frame_err    = run_par ^ bit_in ^ ODD_PARITY;

    // Next-state logic. abort_in wins over everything outside IDLE; in IDLE a
    // simultaneous abort suppresses the start so the block stays put.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_in && !abort_in) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (abort_in) begin
                    state_next = IDLE;
                end else if (bit_valid_in && (bit_idx == LAST_IDX)) begin
                    state_next = PARITY;
                end
            end
            PARITY: begin
                if (abort_in) begin
                    state_next = IDLE;
                end else if (bit_valid_in) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register plus the registered status outputs, which are derived
    // from the next state so they line up with the state they describe.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state    <= IDLE;
            busy_out <= 1'b0;
            done_out <= 1'b0;
        end else begin
            state    <= state_next;
            busy_out <= (state_next != IDLE);
            done_out <= (state_next == DONE);
        end
    end

    // Frame datapath. The shift register and running parity are cleared while
    // idle, so every frame starts clean. data_out/error_out only move when a
    // frame really completes, so aborted frames leave them untouched.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            bit_idx   <= '0;
            shift_reg <= '0;
            run_par   <= 1'b0;
            data_out  <= '0;
            error_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bit_idx   <= '0;
                    shift_reg <= '0;
                    run_par   <= 1'b0;
                end
                DATA: begin
                    if (bit_valid_in && !abort_in) begin
                        shift_reg[bit_idx] <= bit_in;
                        run_par            <= run_par ^ bit_in;
                        bit_idx            <= bit_idx + IDX_W'(1);
                    end
                end
                PARITY: begin
                    if (frame_accept) begin
                        data_out  <= shift_reg;
                        error_out <= frame_err;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Saturating error counter; a clear in the same cycle as an increment wins.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            err_count_out <= '0;
        end else if (clear_cnt_in) begin
            err_count_out <= '0;
        end else if (frame_accept && frame_err && (err_count_out != CNT_MAX)) begin
            err_count_out <= err_count_out + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_parity_frame_checker.sv
// tb_parity_frame_checker
//
// Drives two instances with identical serial stimulus: one even-parity with a
// 2-bit counter (to reach saturation quickly) and one odd-parity with an
// 8-bit counter. Table entries hold the frame and the hand-computed results
// for both instances; hand-written sequences cover abort, ignored starts,
// clear/increment collision and asynchronous reset mid-frame.

module tb_parity_frame_checker;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       bit_valid;
    logic       bit_d;
    logic       clear;

    logic       busy_e,  busy_o;
    logic [7:0] data_e,  data_o;
    logic       done_e,  done_o;
    logic       err_e,   err_o;
    logic [1:0] cnt_e;
    logic [7:0] cnt_o;

    int checks   = 0;
    int failures = 0;

    parity_frame_checker #(
        .DATA_W     (8),
        .ODD_PARITY (1'b0),
        .CNT_W      (2)
    ) dut_even (
        .clk_in        (clk),
        .rst_n_in      (rst_n),
        .start_in      (start),
        .abort_in      (abort),
        .bit_valid_in  (bit_valid),
        .bit_in        (bit_d),
        .clear_cnt_in  (clear),
        .busy_out      (busy_e),
        .data_out      (data_e),
        .done_out      (done_e),
        .error_out     (err_e),
        .err_count_out (cnt_e)
    );

    parity_frame_checker #(
        .DATA_W     (8),
        .ODD_PARITY (1'b1),
        .CNT_W      (8)
    ) dut_odd (
        .clk_in        (clk),
        .rst_n_in      (rst_n),
        .start_in      (start),
        .abort_in      (abort),
        .bit_valid_in  (bit_valid),
        .bit_in        (bit_d),
        .clear_cnt_in  (clear),
        .busy_out      (busy_o),
        .data_out      (data_o),
        .done_out      (done_o),
        .error_out     (err_o),
        .err_count_out (cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       par;
        bit         gap;
        logic       exp_err_e;
        logic [1:0] exp_cnt_e;
        logic       exp_err_o;
        logic [7:0] exp_cnt_o;
    } frame_vec_t;

    frame_vec_t vecs [10];

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Inputs change on the falling edge; returning on the next falling edge
    // leaves the outputs of the intervening rising edge ready to sample.
    task automatic apply_stimulus(input logic s, input logic a, input logic v,
                                  input logic b, input logic c);
        start     = s;
        abort     = a;
        bit_valid = v;
        bit_d     = b;
        clear     = c;
        @(negedge clk);
    endtask

    task automatic idle_cycle();
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Sends a complete frame and checks done timing and results. hold_start
    // keeps start high through the data phase; clr_at_par asserts the counter
    // clear in the same cycle as the parity bit.
    task automatic send_frame(input string tag, input logic [7:0] data,
                              input logic par, input bit gap,
                              input bit hold_start, input bit clr_at_par,
                              input logic exp_err_e, input logic [1:0] exp_cnt_e,
                              input logic exp_err_o, input logic [7:0] exp_cnt_o);
        bit bad;
        bad = 1'b0;
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            if (done_e || done_o || !busy_e || !busy_o) bad = 1'b1;
            if (gap) begin
                apply_stimulus(hold_start, 1'b0, 1'b0, 1'b0, 1'b0);
                if (done_e || done_o || !busy_e || !busy_o) bad = 1'b1;
            end
            apply_stimulus(hold_start, 1'b0, 1'b1, data[i], 1'b0);
        end
        if (done_e || done_o || !busy_e || !busy_o) bad = 1'b1;
        if (gap) begin
            apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            if (done_e || done_o || !busy_e || !busy_o) bad = 1'b1;
        end
        apply_stimulus(1'b0, 1'b0, 1'b1, par, clr_at_par);
        check_output({tag, " in_frame"}, {31'd0, bad}, 32'd0);
        check_output({tag, " done_e"},   {31'd0, done_e}, 32'd1);
        check_output({tag, " done_o"},   {31'd0, done_o}, 32'd1);
        check_output({tag, " busy_done"}, {31'd0, busy_e}, 32'd1);
        check_output({tag, " data_e"},   {24'd0, data_e}, {24'd0, data});
        check_output({tag, " data_o"},   {24'd0, data_o}, {24'd0, data});
        check_output({tag, " err_e"},    {31'd0, err_e}, {31'd0, exp_err_e});
        check_output({tag, " err_o"},    {31'd0, err_o}, {31'd0, exp_err_o});
        check_output({tag, " cnt_e"},    {30'd0, cnt_e}, {30'd0, exp_cnt_e});
        check_output({tag, " cnt_o"},    {24'd0, cnt_o}, {24'd0, exp_cnt_o});
        idle_cycle();
        check_output({tag, " done_pulse"}, {31'd0, done_e | done_o}, 32'd0);
        check_output({tag, " busy_fall"},  {31'd0, busy_e | busy_o}, 32'd0);
    endtask

    initial begin
        // data, par, gap, err_e, cnt_e, err_o, cnt_o
        vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 8'd1};
        vecs[1] = '{8'hA5, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 8'd1};
        vecs[2] = '{8'h01, 1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 8'd2};
        vecs[3] = '{8'h03, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 8'd2};
        vecs[4] = '{8'h03, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 8'd3};
        vecs[5] = '{8'h03, 1'b1, 1'b1, 1'b1, 2'd3, 1'b0, 8'd3};
        vecs[6] = '{8'h03, 1'b0, 1'b1, 1'b0, 2'd3, 1'b1, 8'd4};
        vecs[7] = '{8'hFF, 1'b1, 1'b0, 1'b1, 2'd3, 1'b0, 8'd4};
        vecs[8] = '{8'h00, 1'b1, 1'b0, 1'b1, 2'd3, 1'b0, 8'd4};
        vecs[9] = '{8'h80, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 8'd4};

        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        bit_valid = 1'b0;
        bit_d     = 1'b0;
        clear     = 1'b0;
        repeat (2) @(negedge clk);
        check_output("rst busy",  {30'd0, busy_e, busy_o}, 32'd0);
        check_output("rst done",  {30'd0, done_e, done_o}, 32'd0);
        check_output("rst data",  {16'd0, data_e, data_o}, 32'd0);
        check_output("rst err",   {30'd0, err_e, err_o},   32'd0);
        check_output("rst cnt",   {22'd0, cnt_e, cnt_o},   32'd0);
        rst_n = 1'b1;
        idle_cycle();

        // Table-driven frames, back to back at minimum spacing.
        for (int i = 0; i < 10; i++) begin
            send_frame($sformatf("vec%0d", i), vecs[i].data, vecs[i].par,
                       vecs[i].gap, 1'b0, 1'b0, vecs[i].exp_err_e,
                       vecs[i].exp_cnt_e, vecs[i].exp_err_o, vecs[i].exp_cnt_o);
        end

        // Abort after four data bits: no done, results keep frame 0x80.
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_output("abort busy", {30'd0, busy_e, busy_o}, 32'd0);
        check_output("abort done", {30'd0, done_e, done_o}, 32'd0);
        check_output("abort data", {16'd0, data_e, data_o}, 32'h8080);
        check_output("abort err",  {30'd0, err_e, err_o},   32'd2);
        idle_cycle();
        check_output("abort idle done", {30'd0, done_e, done_o}, 32'd0);

        // Abort while the parity bit is valid: odd count must not move.
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check_output("abort_par done", {30'd0, done_e, done_o}, 32'd0);
        check_output("abort_par cnt_o", {24'd0, cnt_o}, 32'd4);
        check_output("abort_par data_o", {24'd0, data_o}, 32'h80);
        idle_cycle();
        check_output("abort_par late done", {30'd0, done_e, done_o}, 32'd0);

        // start together with abort in IDLE stays idle.
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check_output("start_abort busy", {30'd0, busy_e, busy_o}, 32'd0);

        // start held high during DATA is ignored; frame completes normally.
        send_frame("start_hold", 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0,
                   1'b0, 2'd3, 1'b1, 8'd5);

        // start in the DONE cycle is ignored.
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check_output("done_start done", {30'd0, done_e, done_o}, 32'd3);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_output("done_start busy", {30'd0, busy_e, busy_o}, 32'd0);
        idle_cycle();
        check_output("done_start still idle", {30'd0, busy_e, busy_o}, 32'd0);

        // Clear collides with an errored frame's increment: result is 0.
        send_frame("clr_collide", 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1,
                   1'b1, 2'd0, 1'b0, 8'd0);
        send_frame("after_clr", 8'h01, 1'b0, 1'b0, 1'b0, 1'b0,
                   1'b1, 2'd1, 1'b0, 8'd0);

        // Asynchronous reset in PARITY clears everything immediately.
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        start = 1'b0; bit_valid = 1'b0; bit_d = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_output("mid_rst busy", {30'd0, busy_e, busy_o}, 32'd0);
        check_output("mid_rst data", {16'd0, data_e, data_o}, 32'd0);
        check_output("mid_rst err",  {30'd0, err_e, err_o},   32'd0);
        check_output("mid_rst cnt",  {22'd0, cnt_e, cnt_o},   32'd0);
        check_output("mid_rst done", {30'd0, done_e, done_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycle();
        send_frame("post_rst", 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0,
                   1'b0, 2'd0, 1'b1, 8'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end

endmodule
